// File: rtl/seg_display_pkg.sv
// Shared encodings for the seven-segment display controller and its decoder.
package seg_display_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    localparam logic [1:0] PAGE_ISO       = 2'd0;
    localparam logic [1:0] PAGE_SHUTTER   = 2'd1;
    localparam logic [1:0] PAGE_FOCAL     = 2'd2;
    localparam logic [1:0] PAGE_INDICATOR = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam int         BLANK_CYC = 2;

    function automatic logic [3:0] an_onecold(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_vld;
    logic          r_level;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_accept;

    assign w_diff   = (r_sync2 != r_level);
    assign w_accept = w_diff && (r_cnt == CNT_LAST);
    // A press needs a released sample first, so a button held through reset stays silent.
    assign o_press  = w_accept && r_sync2 && r_armed;
    assign o_level  = r_level;

    // Synchronizer, arming flag and stability counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= {CW{1'b0}};
            end else if (w_diff) begin
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= {CW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Page sequencing and 4-digit multiplexed display drive for the camera-value decoder.
// Optional brightness PWM (duty input) is enabled by defining SEG_BRIGHT_PWM_EN.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 50,
    parameter int AUTO_DIV     = 100000000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef SEG_BRIGHT_PWM_EN
    input  logic [2:0] i_duty,
`endif
    input  logic       i_btn_next,
    input  logic       i_btn_mode,
    input  logic [7:0] i_dig_1,
    input  logic [7:0] i_dig_2,
    input  logic [7:0] i_dig_3,
    input  logic [7:0] i_dig_4,
    output logic [1:0] o_page_sel,
    output logic [3:0] o_an_n,
    output logic [7:0] o_seg_n,
    output logic       o_auto_active,
    output logic       o_page_stb
);

    localparam int            SW         = $clog2(SCAN_DIV);
    localparam int            AW         = $clog2(AUTO_DIV);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_DIV - 1);
    localparam logic [1:0]    BLANK_LAST = 2'(BLANK_CYC - 1);

    logic          w_next_press;
    logic          w_mode_press;
    logic          w_next_level;
    logic          w_mode_level;
    logic [1:0]    w_unused_levels;

    mode_e         r_mode;
    logic [1:0]    r_page;
    logic          r_page_stb;
    logic          r_auto_active;
    logic [AW-1:0] r_auto_cnt;
    logic [1:0]    r_blank_cnt;
    logic          w_term;
    logic          w_adv;
    logic          w_blank;

    logic [SW-1:0] r_slot;
    logic [1:0]    r_dig_idx;
    logic [3:0]    r_an_n;
    logic [7:0]    r_seg_n;
    logic [7:0]    w_dig_sel;
    logic [31:0]   w_slot_ext;
    logic          w_lit;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_next),
        .o_level (w_next_level),
        .o_press (w_next_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_mode),
        .o_level (w_mode_level),
        .o_press (w_mode_press)
    );

    assign w_unused_levels = {w_next_level, w_mode_level};

    assign w_term  = (r_mode == MODE_AUTO) && (r_auto_cnt == AUTO_LAST);
    assign w_adv   = w_next_press || w_term;
    // Decoder output lags page_sel by one cycle, so blank across the change and the stale cycle.
    assign w_blank = w_adv || (r_blank_cnt != 2'd0);

    // Mode FSM, auto-rotation timer, page register and blanking window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode        <= MODE_MANUAL;
            r_auto_active <= 1'b0;
            r_auto_cnt    <= {AW{1'b0}};
            r_page        <= PAGE_ISO;
            r_page_stb    <= 1'b0;
            r_blank_cnt   <= 2'd0;
        end else begin
            case (r_mode)
                MODE_MANUAL: begin
                    r_auto_cnt <= {AW{1'b0}};
                    if (w_mode_press) begin
                        r_mode        <= MODE_AUTO;
                        r_auto_active <= 1'b1;
                    end else begin
                        r_mode        <= MODE_MANUAL;
                        r_auto_active <= 1'b0;
                    end
                end
                MODE_AUTO: begin
                    if (w_mode_press) begin
                        r_mode        <= MODE_MANUAL;
                        r_auto_active <= 1'b0;
                        r_auto_cnt    <= {AW{1'b0}};
                    end else begin
                        r_mode        <= MODE_AUTO;
                        r_auto_active <= 1'b1;
                        r_auto_cnt    <= w_adv ? {AW{1'b0}} : (r_auto_cnt + AW'(1));
                    end
                end
                default: begin
                    r_mode        <= MODE_MANUAL;
                    r_auto_active <= 1'b0;
                    r_auto_cnt    <= {AW{1'b0}};
                end
            endcase
            r_page     <= w_adv ? (r_page + 2'd1) : r_page;
            r_page_stb <= w_adv;
            if (w_adv) begin
                r_blank_cnt <= BLANK_LAST;
            end else if (r_blank_cnt != 2'd0) begin
                r_blank_cnt <= r_blank_cnt - 2'd1;
            end else begin
                r_blank_cnt <= 2'd0;
            end
        end
    end

    assign w_slot_ext = 32'(r_slot);

`ifdef SEG_BRIGHT_PWM_EN
    logic [2:0]  r_duty;
    logic [2:0]  w_duty;
    logic [31:0] w_on_len;

    assign w_duty   = (r_slot == {SW{1'b0}}) ? i_duty : r_duty;
    assign w_on_len = (32'(SCAN_DIV - DEAD_CYC) * (32'(w_duty) + 32'd1)) >> 3;
    assign w_lit    = (w_slot_ext >= 32'(DEAD_CYC)) &&
                      ((w_slot_ext - 32'(DEAD_CYC)) < w_on_len);

    // Duty is captured at slot start and held for the whole slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty <= 3'd0;
        end else begin
            r_duty <= w_duty;
        end
    end
`else
    assign w_lit = (w_slot_ext >= 32'(DEAD_CYC));
`endif

    // Digit pattern for the current scan index.
    always_comb begin
        w_dig_sel = SEG_BLANK;
        case (r_dig_idx)
            2'd0:    w_dig_sel = i_dig_1;
            2'd1:    w_dig_sel = i_dig_2;
            2'd2:    w_dig_sel = i_dig_3;
            2'd3:    w_dig_sel = i_dig_4;
            default: w_dig_sel = SEG_BLANK;
        endcase
    end

    // Free-running scan counters and registered anode/segment drive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot    <= {SW{1'b0}};
            r_dig_idx <= 2'd0;
            r_an_n    <= AN_OFF;
            r_seg_n   <= SEG_BLANK;
        end else begin
            if (r_slot == SLOT_LAST) begin
                r_slot    <= {SW{1'b0}};
                r_dig_idx <= r_dig_idx + 2'd1;
            end else begin
                r_slot    <= r_slot + SW'(1);
                r_dig_idx <= r_dig_idx;
            end
            if (w_blank || !w_lit) begin
                r_an_n  <= AN_OFF;
                r_seg_n <= SEG_BLANK;
            end else begin
                r_an_n  <= an_onecold(r_dig_idx);
                r_seg_n <= w_dig_sel;
            end
        end
    end

    assign o_page_sel    = r_page;
    assign o_page_stb    = r_page_stb;
    assign o_auto_active = r_auto_active;
    assign o_an_n        = r_an_n;
    assign o_seg_n       = r_seg_n;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with small timing parameters; SEG_BRIGHT_PWM_EN adds PWM checks.
module tb_seg_display_ctrl;

    localparam int SCAN = 8;
    localparam int DEAD = 1;
    localparam int AUTO = 64;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_mode = 1'b0;
    logic [7:0] dig_1 = 8'hC0;
    logic [7:0] dig_2 = 8'hF9;
    logic [7:0] dig_3 = 8'hA4;
    logic [7:0] dig_4 = 8'hB0;
    logic [1:0] page_sel;
    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic       auto_active;
    logic       page_stb;
`ifdef SEG_BRIGHT_PWM_EN
    logic [2:0] duty = 3'd7;
`endif

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .SCAN_DIV(SCAN), .DEAD_CYC(DEAD), .AUTO_DIV(AUTO), .DEBOUNCE_CYC(DEB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
`ifdef SEG_BRIGHT_PWM_EN
        .i_duty        (duty),
`endif
        .i_btn_next    (btn_next),
        .i_btn_mode    (btn_mode),
        .i_dig_1       (dig_1),
        .i_dig_2       (dig_2),
        .i_dig_3       (dig_3),
        .i_dig_4       (dig_4),
        .o_page_sel    (page_sel),
        .o_an_n        (an_n),
        .o_seg_n       (seg_n),
        .o_auto_active (auto_active),
        .o_page_stb    (page_stb)
    );

    typedef struct {
        logic [7:0] d1, d2, d3, d4;
        logic [3:0] an;
        logic [7:0] seg;
    } vec_t;

    vec_t       tab [8];
    logic [7:0] dtab [4];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         n;
    logic       seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // cyc counts edges since the last edge that saw rst high.
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else cyc++;
        #1;
    endtask

    task automatic exp_scan(input int c, output logic [3:0] an, output logic [7:0] seg);
        int s, idx;
        an = 4'b1111;
        seg = 8'hFF;
        if (c > 0) begin
            s   = (c - 1) % SCAN;
            idx = ((c - 1) / SCAN) % 4;
            if (s >= DEAD) begin
                an  = ~(4'b0001 << idx);
                seg = dtab[idx];
            end
        end
    endtask

    task automatic chk_scan(input string tag);
        logic [3:0] a;
        logic [7:0] s;
        exp_scan(cyc, a, s);
        chk({tag, "_an"}, 32'(an_n), 32'(a));
        chk({tag, "_seg"}, 32'(seg_n), 32'(s));
    endtask

    task automatic wait_stb(input int max, output int cnt);
        cnt = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (page_stb) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic press_next(input logic [1:0] exp_page);
        btn_next = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("next_early_stb", 32'(page_stb), 32'd0);
        end
        tick();
        chk("next_page", 32'(page_sel), 32'(exp_page));
        chk("next_stb", 32'(page_stb), 32'd1);
        chk("blank0_an", 32'(an_n), 32'hF);
        chk("blank0_seg", 32'(seg_n), 32'hFF);
        btn_next = 1'b0;
        tick();
        chk("stb_once", 32'(page_stb), 32'd0);
        chk("blank1_an", 32'(an_n), 32'hF);
        chk("blank1_seg", 32'(seg_n), 32'hFF);
        tick();
        chk_scan("post_blank");
        repeat (7) tick();
    endtask

    task automatic press_mode(input logic exp_auto);
        btn_mode = 1'b1;
        repeat (5) tick();
        tick();
        chk("mode_auto", 32'(auto_active), 32'(exp_auto));
        chk("mode_nostb", 32'(page_stb), 32'd0);
        btn_mode = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dtab[0] = 8'hC0; dtab[1] = 8'hF9; dtab[2] = 8'hA4; dtab[3] = 8'hB0;
        tab[0] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1110, 8'hC0};
        tab[1] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1101, 8'hF9};
        tab[2] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b1011, 8'hA4};
        tab[3] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0111, 8'hB0};
        tab[4] = '{8'h99, 8'h92, 8'h82, 8'hF8, 4'b1110, 8'h99};
        tab[5] = '{8'h99, 8'h92, 8'h82, 8'hF8, 4'b1101, 8'h92};
        tab[6] = '{8'h99, 8'h92, 8'h82, 8'hF8, 4'b1011, 8'h82};
        tab[7] = '{8'h99, 8'h92, 8'h82, 8'hF8, 4'b0111, 8'hF8};

        // Reset state
        rst = 1'b1;
        tick();
        chk("rst_page", 32'(page_sel), 32'd0);
        chk("rst_auto", 32'(auto_active), 32'd0);
        chk("rst_stb", 32'(page_stb), 32'd0);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'hFF);
        rst = 1'b0;

        // Scan: one slot per table record, dead cycle first
        for (int k = 0; k < 8; k++) begin
            dig_1 = tab[k].d1; dig_2 = tab[k].d2; dig_3 = tab[k].d3; dig_4 = tab[k].d4;
            for (int j = 0; j < SCAN; j++) begin
                tick();
                if (j < DEAD) begin
                    chk("scan_dead_an", 32'(an_n), 32'hF);
                    chk("scan_dead_seg", 32'(seg_n), 32'hFF);
                end else begin
                    chk("scan_an", 32'(an_n), 32'(tab[k].an));
                    chk("scan_seg", 32'(seg_n), 32'(tab[k].seg));
                end
            end
        end
        dig_1 = dtab[0]; dig_2 = dtab[1]; dig_3 = dtab[2]; dig_4 = dtab[3];

        // Short pulse is filtered, long presses advance and wrap
        btn_next = 1'b1;
        repeat (3) tick();
        btn_next = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | page_stb;
        end
        chk("short_nostb", 32'(seen), 32'd0);
        chk("short_page", 32'(page_sel), 32'd0);
        press_next(2'd1);
        press_next(2'd2);
        press_next(2'd3);
        press_next(2'd0);

        // Auto rotation
        press_mode(1'b1);
        wait_stb(100, n);
        chk("auto_period", 32'(n), 32'd64);
        chk("auto_page1", 32'(page_sel), 32'd1);
        repeat (25) tick();
        btn_next = 1'b1;
        repeat (5) tick();
        chk("auto_pre_press_page", 32'(page_sel), 32'd1);
        tick();
        chk("auto_press_stb", 32'(page_stb), 32'd1);
        chk("auto_press_page", 32'(page_sel), 32'd2);
        btn_next = 1'b0;
        wait_stb(100, n);
        chk("auto_after_press", 32'(n), 32'd64);
        chk("auto_page3", 32'(page_sel), 32'd3);
        repeat (58) tick();
        btn_next = 1'b1;
        repeat (5) tick();
        tick();
        chk("coinc_stb", 32'(page_stb), 32'd1);
        chk("coinc_page", 32'(page_sel), 32'd0);
        btn_next = 1'b0;
        tick();
        chk("coinc_stb_once", 32'(page_stb), 32'd0);
        chk("coinc_page_hold", 32'(page_sel), 32'd0);
        wait_stb(100, n);
        chk("coinc_next_period", 32'(n), 32'd63);
        chk("coinc_page1", 32'(page_sel), 32'd1);

        // Mode and next together: toggle plus one advance
        repeat (8) tick();
        btn_next = 1'b1;
        btn_mode = 1'b1;
        repeat (6) tick();
        chk("both_auto", 32'(auto_active), 32'd0);
        chk("both_page", 32'(page_sel), 32'd2);
        chk("both_stb", 32'(page_stb), 32'd1);
        btn_next = 1'b0;
        btn_mode = 1'b0;
        tick();
        chk("both_stb_once", 32'(page_stb), 32'd0);
        wait_stb(70, n);
        chk("manual_no_rotate", 32'(n), 32'd71);
        chk("manual_page", 32'(page_sel), 32'd2);

        // Reset mid-operation with the button held
        press_next(2'd3);
        press_next(2'd0);
        press_next(2'd1);
        press_mode(1'b1);
        btn_next = 1'b1;
        repeat (5) tick();
        tick();
        chk("held_page2", 32'(page_sel), 32'd2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_page", 32'(page_sel), 32'd0);
        chk("mid_rst_auto", 32'(auto_active), 32'd0);
        chk("mid_rst_stb", 32'(page_stb), 32'd0);
        chk("mid_rst_an", 32'(an_n), 32'hF);
        chk("mid_rst_seg", 32'(seg_n), 32'hFF);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | page_stb;
        end
        chk("held_nostb", 32'(seen), 32'd0);
        chk("held_page", 32'(page_sel), 32'd0);
        btn_next = 1'b0;
        repeat (10) tick();
        press_next(2'd1);

`ifdef SEG_BRIGHT_PWM_EN
        // Brightness PWM
        duty = 3'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < SCAN; j++) begin
            tick();
            if (j >= 1 && j <= 3) begin
                chk("pwm3_an", 32'(an_n), 32'hE);
                chk("pwm3_seg", 32'(seg_n), 32'hC0);
            end else begin
                chk("pwm3_off_an", 32'(an_n), 32'hF);
                chk("pwm3_off_seg", 32'(seg_n), 32'hFF);
            end
        end
        duty = 3'd7;
        for (int j = 0; j < SCAN; j++) begin
            tick();
            if (j == 2) duty = 3'd0;
            if (j >= 1) begin
                chk("pwm7_an", 32'(an_n), 32'hD);
                chk("pwm7_seg", 32'(seg_n), 32'hF9);
            end else begin
                chk("pwm7_dead_an", 32'(an_n), 32'hF);
            end
        end
        duty = 3'd7;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Sequences the camera-value seven-segment decoder.
- Owns the decoder's 2-bit page select, chosen by user buttons (manual mode) or a rotation timer (auto mode).
- Time-multiplexes the decoder's four 8-bit digit patterns onto a shared active-low 4-digit display, with anode dead-time and page-change blanking.
- Sits between the button inputs, the decoder, and the board display pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (>=4).
- DEAD_CYC, 50: cycles at the start of each slot with all anodes off (< SCAN_DIV).
- AUTO_DIV, 100000000: clk cycles per page in auto mode.
- DEBOUNCE_CYC, 500000: cycles a synchronized button level must stay stable before it is accepted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- btn_next, input, 1: raw asynchronous button; advances the page.
- btn_mode, input, 1: raw asynchronous button; toggles manual/auto mode.
- dig_1, input, 8: decoder pattern for the rightmost digit; bit7 = DP; active-low.
- dig_2, input, 8: decoder pattern for digit 2.
- dig_3, input, 8: decoder pattern for digit 3.
- dig_4, input, 8: decoder pattern for the leftmost digit.
- page_sel, output, 2: page select to the decoder (0 ISO, 1 shutter, 2 focal, 3 indicator).
- an_n, output, 4: one-cold anode enables; bit0 = rightmost digit.
- seg_n, output, 8: active-low segments plus DP.
- auto_active, output, 1: high while in AUTO.
- page_stb, output, 1: one-cycle pulse on every page_sel change.

Behaviour:
- Reset (rst high at a clk edge): page_sel=0, mode MANUAL, auto_active=0, page_stb=0, an_n=4'b1111, seg_n=8'hFF. Digit index, all counters and the debouncers clear to 0/released.
- Debounce, per button:
  - 2-FF synchronizer, then a stability counter.
  - The accepted level changes only after DEBOUNCE_CYC consecutive equal samples.
  - A 0->1 change of the accepted level produces a one-cycle press pulse.
  - Total press latency from raw edge: 2 + DEBOUNCE_CYC cycles.
- Mode FSM (states MANUAL and AUTO):
  - A mode press toggles the state.
  - Entering AUTO clears the auto timer.
- Page advance:
  - page_sel increments modulo 4 (3 -> 0).
  - Triggers: a next press in either state, or auto-timer terminal count (AUTO_DIV-1) in AUTO.
  - A next press in AUTO also clears the auto timer.
  - A timer terminal count and a next press in the same cycle produce exactly one advance.
  - A mode press and a next press in the same cycle: the toggle applies and exactly one advance occurs.
  - page_sel and page_stb are registered; page_stb asserts in the cycle page_sel takes its new value.
- Page-change blanking:
  - The decoder is registered, so its outputs are stale for one cycle after a page change.
  - For the 2 cycles after page_stb (the page_stb cycle and the next), seg_n=8'hFF and an_n=4'b1111.
  - The scan counters keep running during blanking.
- Digit scan:
  - The slot counter runs 0..SCAN_DIV-1. At terminal count the digit index advances 0->1->2->3->0.
  - Slot cycles 0..DEAD_CYC-1: an_n=4'b1111, seg_n=8'hFF.
  - Rest of slot: an_n clears only the bit of the current digit index; seg_n = dig_(index+1).
  - an_n and seg_n are registered (one cycle after the counter state) and change in the same cycle, so there is no glitch.
  - The scan free-runs, independent of mode.
- Reset mid-operation: all state returns to reset values on the next edge. A button held through reset is not reported as a press until it is released and pressed again.

Optional Feature:
- Macro SEG_BRIGHT_PWM_EN.
- When defined:
  - Adds input port duty, 3 bits.
  - After dead-time, the anode is enabled only while (slot_count - DEAD_CYC) < ((SCAN_DIV-DEAD_CYC)*(duty+1))>>3; otherwise an_n=4'b1111 and seg_n=8'hFF.
  - duty=7 matches the undefined behaviour.
  - duty is sampled at slot start.
- When undefined: no duty port; full post-dead-time slot.

Decomposition:
- Shared package seg_display_pkg:
  - Mode state encoding MODE_MANUAL=0, MODE_AUTO=1.
  - Page codes PAGE_ISO=0, PAGE_SHUTTER=1, PAGE_FOCAL=2, PAGE_INDICATOR=3.
  - SEG_BLANK=8'hFF, AN_OFF=4'b1111, BLANK_CYC=2.
- One sub-module, btn_debounce: parameter DEBOUNCE_CYC; ports clk, rst, raw, level, press. Instantiated twice.

Test Plan (SCAN_DIV=8, DEAD_CYC=1, AUTO_DIV=64, DEBOUNCE_CYC=4):
1. Reset, then dig_1..4 = 8'hC0/F9/A4/B0 -> an_n cycles 1110, 1101, 1011, 0111, each held for 7 cycles after 1 cycle of 1111; seg_n = C0, F9, A4, B0 respectively.
2. btn_next pulses 3 cycles, then 6 cycles high -> no press for the short pulse. The long press gives page_sel 0->1 and page_stb exactly 6 cycles after the rising edge. Four accepted presses wrap page_sel back to 0.
3. Mode press -> auto_active=1; page_sel advances every 64 cycles. A next press at timer count 30 advances immediately and the next auto advance is 64 cycles later. Press timed to coincide with terminal count -> page_sel changes by exactly 1.
4. Page change at any scan phase -> an_n=1111 and seg_n=FF for exactly 2 cycles starting at page_stb; the scan digit index continues unaffected.
5. Assert rst mid-slot in AUTO with page_sel=2 and btn_next held -> next cycle all reset values. Releasing rst with the button still held produces no press.
6. With SEG_BRIGHT_PWM_EN and duty=3 -> per 8-cycle slot: 1 dead cycle, anode on for 3 cycles ((7*4)>>3=3), off for 4. With duty=7 -> on for 7.
